load_store_unit: RTL and testbench

- Multi-cycle load/store unit in the MEM stage of the RISC-V core.
- Takes one load or store request per transaction and drives a req/ack data-memory bus.
- Formats load data (byte/half lane select, sign/zero extension) onto rdata_out, which feeds the writeback result multiplexer's memory-data input.
- Stores are lane-replicated with byte enables; misaligned, illegal and timed-out accesses are reported as faults.

---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one request per transaction over a req/ack data bus,
// with lane formatting of load/store data and fault reporting.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_MISALGN = 2'b01;
  localparam logic [1:0] CODE_ILLEGAL = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  state_t        state, next_state;
  logic [1:0]    code_r, next_code;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_r;
  logic [1:0]    lane_r;

  logic          illegal, misaligned, accept, timeout_hit, ack_seen;
  logic [31:0]   st_wdata, load_fmt;
  logic [3:0]    st_be;
  logic [7:0]    byte_lane;
  logic [15:0]   half_lane;

  // Request decode on the raw inputs; only meaningful while IDLE.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (is_store)
      illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else
      illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign accept      = start & ~illegal & ~misaligned;
  assign ack_seen    = mem_ack & mem_req;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    st_wdata = wdata_in;
    st_be    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{wdata_in[7:0]}};
        st_be    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{wdata_in[15:0]}};
        st_be    = 4'b0011 << addr[1:0];
      end
      default: begin
        st_wdata = wdata_in;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Load lane select and extension use the request latched at accept time.
  always_comb begin
    byte_lane = mem_rdata[{lane_r, 3'b000} +: 8];
    half_lane = mem_rdata[{lane_r[1], 4'b0000} +: 16];
    load_fmt  = mem_rdata;
    case (f3_r[1:0])
      2'b00:   load_fmt = {{24{~f3_r[2] & byte_lane[7]}}, byte_lane};
      2'b01:   load_fmt = {{16{~f3_r[2] & half_lane[15]}}, half_lane};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      code_r <= CODE_NONE;
    end else begin
      state  <= next_state;
      code_r <= next_code;
    end
  end

  // Timeout wins over an ack arriving in the same cycle.
  always_comb begin
    next_state = state;
    next_code  = code_r;
    case (state)
      IDLE: begin
        if (start) begin
          if (illegal) begin
            next_code  = CODE_ILLEGAL;
            next_state = DONE;
          end else if (misaligned) begin
            next_code  = CODE_MISALGN;
            next_state = DONE;
          end else begin
            next_code  = CODE_NONE;
            next_state = BUS;
          end
        end
      end
      BUS: begin
        if (timeout_hit) begin
          next_code  = CODE_TIMEOUT;
          next_state = DONE;
        end else if (ack_seen) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      f3_r      <= 3'b000;
      lane_r    <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'h0;
      rdata_out <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= is_store ? st_wdata : 32'h0;
            mem_be    <= is_store ? st_be : 4'b1111;
            f3_r      <= funct3;
            lane_r    <= addr[1:0];
          end
        end
        BUS: begin
          if (timeout_hit) begin
            mem_req <= 1'b0;
          end else if (ack_seen) begin
            mem_req <= 1'b0;
            if (!mem_we)
              rdata_out <= load_fmt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign fault_code = done ? code_r : CODE_NONE;
  assign fault      = done & (code_r != CODE_NONE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with TIMEOUT=4.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        busy;
  logic        done;
  logic [31:0] rdata_out;
  logic        fault;
  logic [1:0]  fault_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata_in   (wdata_in),
    .busy       (busy),
    .done       (done),
    .rdata_out  (rdata_out),
    .fault      (fault),
    .fault_code (fault_code),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns in the cycle after start.
  task automatic applyStimulus(input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    start    = 1'b1;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata_in = wd;
    step();
    start    = 1'b0;
  endtask

  task automatic busLoad(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp_rd);
    applyStimulus(1'b0, f3, a, 32'h0);
    checkOutput({tag, ".req"},  {31'h0, mem_req}, 32'h1);
    checkOutput({tag, ".we"},   {31'h0, mem_we}, 32'h0);
    checkOutput({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
    checkOutput({tag, ".be"},   {28'h0, mem_be}, 32'hF);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack   = 1'b0;
    checkOutput({tag, ".done"},  {31'h0, done}, 32'h1);
    checkOutput({tag, ".fault"}, {31'h0, fault}, 32'h0);
    checkOutput({tag, ".reqlo"}, {31'h0, mem_req}, 32'h0);
    checkOutput({tag, ".rdata"}, rdata_out, exp_rd);
    step();
    checkOutput({tag, ".idle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic busStore(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] hold_rd);
    applyStimulus(1'b1, f3, a, wd);
    checkOutput({tag, ".req"},   {31'h0, mem_req}, 32'h1);
    checkOutput({tag, ".we"},    {31'h0, mem_we}, 32'h1);
    checkOutput({tag, ".addr"},  mem_addr, {a[31:2], 2'b00});
    checkOutput({tag, ".be"},    {28'h0, mem_be}, {28'h0, exp_be});
    checkOutput({tag, ".wdata"}, mem_wdata, exp_wd);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack   = 1'b0;
    checkOutput({tag, ".done"},  {31'h0, done}, 32'h1);
    checkOutput({tag, ".fault"}, {31'h0, fault}, 32'h0);
    checkOutput({tag, ".rdata"}, rdata_out, hold_rd);
    step();
  endtask

  task automatic faultCheck(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [1:0] exp_code,
                            input logic [31:0] hold_rd);
    applyStimulus(st, f3, a, 32'h5555_AAAA);
    checkOutput({tag, ".req"},   {31'h0, mem_req}, 32'h0);
    checkOutput({tag, ".done"},  {31'h0, done}, 32'h1);
    checkOutput({tag, ".fault"}, {31'h0, fault}, 32'h1);
    checkOutput({tag, ".code"},  {30'h0, fault_code}, {30'h0, exp_code});
    checkOutput({tag, ".rdata"}, rdata_out, hold_rd);
    step();
    checkOutput({tag, ".donelo"}, {31'h0, done}, 32'h0);
    checkOutput({tag, ".codelo"}, {30'h0, fault_code}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  req_cycles;
    bit  seen_done;

    rst       = 1'b1;
    start     = 1'b0;
    is_store  = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata_in  = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    step();
    step();
    checkOutput("rst.busy",  {31'h0, busy}, 32'h0);
    checkOutput("rst.done",  {31'h0, done}, 32'h0);
    checkOutput("rst.req",   {31'h0, mem_req}, 32'h0);
    checkOutput("rst.rdata", rdata_out, 32'h0);
    checkOutput("rst.code",  {30'h0, fault_code}, 32'h0);
    checkOutput("rst.be",    {28'h0, mem_be}, 32'h0);
    rst = 1'b0;
    step();
    checkOutput("post_rst.busy", {31'h0, busy}, 32'h0);

    busLoad("lb_103",  3'b000, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80);
    busLoad("lhu_202", 3'b101, 32'h0000_0202, 32'h8001_7FFF, 32'h0000_8001);
    busLoad("lh_202",  3'b001, 32'h0000_0202, 32'h8001_7FFF, 32'hFFFF_8001);

    busStore("sb_301", 3'b000, 32'h0000_0301, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB, 32'hFFFF_8001);
    busStore("sh_302", 3'b001, 32'h0000_0302, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_8001);
    busStore("sw_300", 3'b010, 32'h0000_0300, 32'hCAFE_1234, 4'b1111, 32'hCAFE_1234, 32'hFFFF_8001);

    faultCheck("lw_mis",   1'b0, 3'b010, 32'h0000_0102, 2'b01, 32'hFFFF_8001);
    faultCheck("ld_ill",   1'b0, 3'b011, 32'h0000_0100, 2'b10, 32'hFFFF_8001);
    faultCheck("st_ilmis", 1'b1, 3'b100, 32'h0000_0101, 2'b10, 32'hFFFF_8001);
    faultCheck("lh_mis",   1'b0, 3'b001, 32'h0000_0201, 2'b01, 32'hFFFF_8001);

    busLoad("lbu_101", 3'b100, 32'h0000_0101, 32'h0000_F000, 32'h0000_00F0);
    busLoad("lb_100",  3'b000, 32'h0000_0100, 32'h1234_567F, 32'h0000_007F);

    // Stalled bus: mem_req must stay up exactly TIMEOUT cycles; ack in the last one is ignored.
    applyStimulus(1'b0, 3'b010, 32'h0000_0400, 32'h0);
    req_cycles = 0;
    seen_done  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (mem_req) req_cycles++;
      mem_ack   = (req_cycles == 4);
      mem_rdata = 32'h9999_9999;
      step();
    end
    checkOutput("to.done",   {31'h0, seen_done}, 32'h1);
    checkOutput("to.cycles", req_cycles, 32'd4);
    checkOutput("to.code",   {30'h0, fault_code}, 32'h3);
    checkOutput("to.fault",  {31'h0, fault}, 32'h1);
    checkOutput("to.rdata",  rdata_out, 32'h0000_007F);
    step();
    checkOutput("late_ack.busy", {31'h0, busy}, 32'h0);
    checkOutput("late_ack.done", {31'h0, done}, 32'h0);
    mem_ack = 1'b0;
    step();

    // A start pulse during a stalled load must neither disturb it nor be queued.
    applyStimulus(1'b0, 3'b010, 32'h0000_0600, 32'h0);
    step();
    start    = 1'b1;
    is_store = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h0000_0700;
    wdata_in = 32'h7777_7777;
    step();
    start = 1'b0;
    checkOutput("busy_start.we",   {31'h0, mem_we}, 32'h0);
    checkOutput("busy_start.addr", mem_addr, 32'h0000_0600);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1122_3344;
    step();
    mem_ack = 1'b0;
    checkOutput("busy_start.done",  {31'h0, done}, 32'h1);
    checkOutput("busy_start.rdata", rdata_out, 32'h1122_3344);
    step();
    checkOutput("busy_start.noqueue", {31'h0, busy}, 32'h0);
    step();
    checkOutput("busy_start.noreq", {31'h0, mem_req}, 32'h0);

    // Asynchronous reset in the middle of a stalled access.
    applyStimulus(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    checkOutput("midrst.req_before", {31'h0, mem_req}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst.req",   {31'h0, mem_req}, 32'h0);
    checkOutput("midrst.busy",  {31'h0, busy}, 32'h0);
    checkOutput("midrst.rdata", rdata_out, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    checkOutput("midrst.noretry", {31'h0, mem_req}, 32'h0);
    busLoad("lw_504", 3'b010, 32'h0000_0504, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
